ddr_refresh_ctrl: RTL and testbench

Refresh timing engine that sits directly upstream of the controller FSM. It runs the tREFI interval timer and accumulates postponed refreshes. It raises `refresh_almost` so the controller can drain read/write traffic. When the controller grants the slot, it sequences PREA → tRP → REF → tRFC and reports completion on `refresh_done`. Its `prea_cmd`/`ref_cmd` pulses feed the command decoder.

---
 rtl/ddr_refresh_ctrl_if.sv | 25 ++
 rtl/ddr_refresh_ctrl.sv | 125 ++++++++++++
 tb/tb_ddr_refresh_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_refresh_ctrl_if.sv
// rtl/ddr_refresh_ctrl_if.sv - controller <-> refresh engine handshake and status bundle
interface ddr_refresh_ctrl_if;
    logic       ini_done;
    logic       busy;
    logic       clear_refresh;
    logic       refresh_almost;
    logic       refresh_done;
    logic       refresh_urgent;
    logic       prea_cmd;
    logic       ref_cmd;
    logic [3:0] pending;
    logic       ref_overflow;

    modport master (
        output ini_done, busy, clear_refresh,
        input  refresh_almost, refresh_done, refresh_urgent,
        input  prea_cmd, ref_cmd, pending, ref_overflow
    );

    modport slave (
        input  ini_done, busy, clear_refresh,
        output refresh_almost, refresh_done, refresh_urgent,
        output prea_cmd, ref_cmd, pending, ref_overflow
    );
endinterface

// File: rtl/ddr_refresh_ctrl.sv
// rtl/ddr_refresh_ctrl.sv - tREFI timer, postponed-refresh accounting and PREA/REF sequencer
module ddr_refresh_ctrl #(
    parameter int T_REFI        = 6240,
    parameter int T_RFC         = 280,
    parameter int T_RP          = 11,
    parameter int ALMOST_MARGIN = 64,
    parameter int MAX_PEND      = 8
) (
    input  logic               CK_t,
    input  logic               reset_n,
    ddr_refresh_ctrl_if.slave  rif
);
    localparam int IW      = $clog2(T_REFI);
    localparam int SEQ_MAX = (T_RFC > T_RP) ? T_RFC : T_RP;
    localparam int CW      = $clog2(SEQ_MAX);

    localparam logic [IW-1:0] ICNT_LAST = IW'(T_REFI - 1);
    localparam logic [IW-1:0] ALMOST_TH = IW'(T_REFI - ALMOST_MARGIN);
    localparam logic [3:0]    PEND_MAX  = 4'(MAX_PEND);
    localparam logic [CW-1:0] RP_LOAD   = CW'(T_RP - 2);
    localparam logic [CW-1:0] RFC_LOAD  = CW'(T_RFC - 2);

    typedef enum logic [2:0] {R_IDLE, R_PREA, R_TRP, R_REF, R_TRFC, R_DONE} state_t;

    state_t        state;
    logic [IW-1:0] icnt;
    logic [CW-1:0] wcnt;
    logic [3:0]    pend;
    logic          almost_q, done_q, urgent_q, prea_q, ref_q, ovf_q;

    logic [IW-1:0] icnt_nx;
    logic [3:0]    pend_nx;
    logic          tick, dec, ovf_set;

    // Tick and REF decrement cancel; decrement is gated so a cleared count cannot underflow.
    always_comb begin
        tick    = (icnt == ICNT_LAST);
        dec     = ref_q && (pend != 4'd0);
        icnt_nx = '0;
        pend_nx = pend;
        ovf_set = 1'b0;
        if (!rif.ini_done) begin
            pend_nx = 4'd0;
        end else begin
            icnt_nx = tick ? '0 : icnt + IW'(1);
            if (tick && !dec) begin
                if (pend == PEND_MAX) ovf_set = 1'b1;
                else                  pend_nx = pend + 4'd1;
            end else if (dec && !tick) begin
                pend_nx = pend - 4'd1;
            end
        end
    end

    always_ff @(posedge CK_t) begin
        if (!reset_n) begin
            state    <= R_IDLE;
            icnt     <= '0;
            wcnt     <= '0;
            pend     <= 4'd0;
            almost_q <= 1'b0;
            done_q   <= 1'b0;
            urgent_q <= 1'b0;
            prea_q   <= 1'b0;
            ref_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            icnt     <= icnt_nx;
            pend     <= pend_nx;
            almost_q <= (pend_nx != 4'd0) || (icnt_nx >= ALMOST_TH);
            urgent_q <= (pend_nx == PEND_MAX);
            if (ovf_set) ovf_q <= 1'b1;
            prea_q   <= 1'b0;
            ref_q    <= 1'b0;
            // Wait counters load N-2: one cycle is spent in the pulse state, one on the exit edge.
            case (state)
                R_IDLE: begin
                    if (pend != 4'd0 && rif.busy && !rif.clear_refresh) begin
                        state  <= R_PREA;
                        prea_q <= 1'b1;
                    end
                end
                R_PREA: begin
                    state <= R_TRP;
                    wcnt  <= RP_LOAD;
                end
                R_TRP: begin
                    if (wcnt == '0) begin
                        state <= R_REF;
                        ref_q <= 1'b1;
                    end else begin
                        wcnt <= wcnt - CW'(1);
                    end
                end
                R_REF: begin
                    state <= R_TRFC;
                    wcnt  <= RFC_LOAD;
                end
                R_TRFC: begin
                    if (wcnt == '0) begin
                        state  <= R_DONE;
                        done_q <= 1'b1;
                    end else begin
                        wcnt <= wcnt - CW'(1);
                    end
                end
                R_DONE: begin
                    if (rif.clear_refresh) begin
                        state  <= R_IDLE;
                        done_q <= 1'b0;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

    assign rif.refresh_almost = almost_q;
    assign rif.refresh_done   = done_q;
    assign rif.refresh_urgent = urgent_q;
    assign rif.prea_cmd       = prea_q;
    assign rif.ref_cmd        = ref_q;
    assign rif.pending        = pend;
    assign rif.ref_overflow   = ovf_q;
endmodule

// File: tb/tb_ddr_refresh_ctrl.sv
// tb/tb_ddr_refresh_ctrl.sv - scoreboard bench for ddr_refresh_ctrl
module tb_ddr_refresh_ctrl;
    localparam int T_REFI = 100;
    localparam int T_RFC  = 20;
    localparam int T_RP   = 5;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic CK_t = 1'b0;
    logic reset_n;
    ddr_refresh_ctrl_if rif ();

    ddr_refresh_ctrl #(
        .T_REFI(T_REFI), .T_RFC(T_RFC), .T_RP(T_RP), .ALMOST_MARGIN(10), .MAX_PEND(8)
    ) dut (
        .CK_t   (CK_t),
        .reset_n(reset_n),
        .rif    (rif)
    );

    always #5 CK_t = ~CK_t;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    ev_t exp_q[$];
    bit  prea_p = 1'b0, ref_p = 1'b0, done_p = 1'b0;

    function automatic string ev_name(input int k);
        case (k)
            0:       return "prea_cmd";
            1:       return "ref_cmd";
            default: return "refresh_done";
        endcase
    endfunction

    // Advance one clock and pop any pulse edges the DUT produced against the expected queue.
    task automatic step();
        logic [2:0] rise;
        bit pr, rf;
        ev_t ev;
        @(posedge CK_t);
        cyc++;
        #1;
        pr = (rif.prea_cmd === 1'b1);
        rf = (rif.ref_cmd === 1'b1);
        rise = {(rif.refresh_done === 1'b1) && !done_p, rf && !ref_p, pr && !prea_p};
        for (int k = 0; k < 3; k++) begin
            if (rise[k]) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_%s: got rise at cycle %0d, required none", ev_name(k), cyc);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.kind != k || ev.cyc != cyc) begin
                        n_fail++;
                        $display("FAIL %s_timing: got %s at cycle %0d, required %s at cycle %0d",
                                 ev_name(ev.kind), ev_name(k), cyc, ev_name(ev.kind), ev.cyc);
                    end
                end
            end
        end
        if (pr || rf) begin
            n_tests++;
            if ((pr && rf) || (pr && prea_p) || (rf && ref_p)) begin
                n_fail++;
                $display("FAIL cmd_pulse: got prea=%b ref=%b (prev %b %b) at cycle %0d, required single isolated pulse",
                         pr, rf, prea_p, ref_p, cyc);
            end
        end
        prea_p = pr;
        ref_p  = rf;
        done_p = (rif.refresh_done === 1'b1);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) step();
    endtask

    task automatic push_seq(input int g, input bit with_done);
        exp_q.push_back('{0, g});
        exp_q.push_back('{1, g + T_RP});
        if (with_done) exp_q.push_back('{2, g + T_RP + T_RFC});
    endtask

    // Drives a grant now; it is sampled on the next edge, whose cycle number is returned.
    task automatic grant(input bit with_done, output int g);
        rif.busy = 1'b1;
        rif.clear_refresh = 1'b0;
        g = cyc + 1;
        push_seq(g, with_done);
        step();
        rif.busy = 1'b0;
    endtask

    task automatic check_queue_empty(input string name);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing: got %0d outstanding pulses, required 0 (next %s at cycle %0d)",
                     name, exp_q.size(), ev_name(exp_q[0].kind), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic check_val(input string name, input logic [3:0] got, input logic [3:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at cycle %0d", name, got, req, cyc);
        end
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        reset_n = 1'b0;
        rif.ini_done = 1'b0;
        rif.busy = 1'b0;
        rif.clear_refresh = 1'b0;
        repeat (3) step();
        obs = {rif.refresh_almost, rif.refresh_done, rif.refresh_urgent, rif.prea_cmd,
               rif.ref_cmd, rif.pending, rif.ref_overflow};
        n_tests++;
        if (obs !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required all zero", obs);
        end
        reset_n = 1'b1;
        repeat (5) step();
        check_val("idle_no_ini_pending", rif.pending, 4'd0);
        check_val("idle_no_ini_almost", {3'd0, rif.refresh_almost}, 4'd0);
    endtask

    task automatic test_interval(output int c0);
        c0 = cyc;
        rif.ini_done = 1'b1;
        wait_cyc(c0 + 89);
        check_val("interval_almost_before", {3'd0, rif.refresh_almost}, 4'd0);
        step();
        check_val("interval_almost_rise", {3'd0, rif.refresh_almost}, 4'd1);
        wait_cyc(c0 + 99);
        check_val("interval_pending_before", rif.pending, 4'd0);
        step();
        check_val("interval_pending_tick", rif.pending, 4'd1);
        check_val("interval_quiet", {1'b0, rif.refresh_done, rif.refresh_urgent, rif.ref_overflow}, 4'd0);
    endtask

    task automatic test_sequence();
        int g;
        grant(1'b1, g);
        wait_cyc(g + T_RP);
        check_val("seq_pending_at_ref", rif.pending, 4'd1);
        step();
        check_val("seq_pending_after_ref", rif.pending, 4'd0);
        wait_cyc(g + 30);
        check_val("seq_done_held", {3'd0, rif.refresh_done}, 4'd1);
        rif.clear_refresh = 1'b1;
        step();
        rif.clear_refresh = 1'b0;
        check_val("seq_done_cleared", {3'd0, rif.refresh_done}, 4'd0);
        check_val("seq_almost_idle", {3'd0, rif.refresh_almost}, 4'd0);
        check_queue_empty("seq");
    endtask

    task automatic test_overflow(input int c0);
        int g;
        wait_cyc(c0 + 899);
        check_val("ovf_pending_7", rif.pending, 4'd7);
        check_val("ovf_urgent_before", {3'd0, rif.refresh_urgent}, 4'd0);
        step();
        check_val("ovf_pending_8", rif.pending, 4'd8);
        check_val("ovf_urgent_at_8", {3'd0, rif.refresh_urgent}, 4'd1);
        check_val("ovf_not_yet", {3'd0, rif.ref_overflow}, 4'd0);
        wait_cyc(c0 + 1000);
        check_val("ovf_pending_sat", rif.pending, 4'd8);
        check_val("ovf_set", {3'd0, rif.ref_overflow}, 4'd1);
        grant(1'b1, g);
        wait_cyc(g + T_RP + 1);
        check_val("ovf_pending_after_ref", rif.pending, 4'd7);
        check_val("ovf_urgent_drop", {3'd0, rif.refresh_urgent}, 4'd0);
        wait_cyc(g + T_RP + T_RFC);
        rif.clear_refresh = 1'b1;
        step();
        rif.clear_refresh = 1'b0;
        check_val("ovf_min_latency_idle", {3'd0, rif.refresh_done}, 4'd0);
        check_val("ovf_sticky", {3'd0, rif.ref_overflow}, 4'd1);
        check_queue_empty("ovf");
    endtask

    task automatic test_collision(output int r);
        int g;
        reset_n = 1'b0;
        repeat (2) step();
        check_val("coll_reset_ovf", {3'd0, rif.ref_overflow}, 4'd0);
        check_val("coll_reset_pending", rif.pending, 4'd0);
        reset_n = 1'b1;
        r = cyc;
        wait_cyc(r + 200);
        check_val("coll_pending_2", rif.pending, 4'd2);
        wait_cyc(r + 293);
        grant(1'b1, g);
        wait_cyc(g + T_RP);
        check_val("coll_pending_at_ref", rif.pending, 4'd2);
        step();
        check_val("coll_pending_same", rif.pending, 4'd2);
        check_val("coll_no_ovf", {3'd0, rif.ref_overflow}, 4'd0);
        wait_cyc(g + T_RP + T_RFC);
        rif.clear_refresh = 1'b1;
        step();
        rif.clear_refresh = 1'b0;
        check_queue_empty("coll");
    endtask

    task automatic test_reset_mid(output int r2);
        int g;
        logic [9:0] obs;
        grant(1'b0, g);
        wait_cyc(g + 10);
        reset_n = 1'b0;
        step();
        obs = {rif.refresh_almost, rif.refresh_done, rif.refresh_urgent, rif.prea_cmd,
               rif.ref_cmd, rif.pending, rif.ref_overflow};
        n_tests++;
        if (obs !== 10'd0) begin
            n_fail++;
            $display("FAIL midseq_reset_outputs: got %b, required all zero", obs);
        end
        step();
        reset_n = 1'b1;
        r2 = cyc;
        wait_cyc(r2 + 89);
        check_val("midseq_restart_almost_before", {3'd0, rif.refresh_almost}, 4'd0);
        step();
        check_val("midseq_restart_almost_rise", {3'd0, rif.refresh_almost}, 4'd1);
        wait_cyc(r2 + 100);
        check_val("midseq_restart_pending", rif.pending, 4'd1);
        check_val("midseq_no_done", {3'd0, rif.refresh_done}, 4'd0);
        check_queue_empty("midseq");
    endtask

    task automatic test_toggle();
        int g;
        grant(1'b1, g);
        for (int i = 0; i < 24; i++) begin
            rif.busy = i[0];
            rif.clear_refresh = ~i[0];
            step();
        end
        rif.busy = 1'b0;
        rif.clear_refresh = 1'b0;
        wait_cyc(g + T_RP + T_RFC + 2);
        check_val("toggle_done_held", {3'd0, rif.refresh_done}, 4'd1);
        check_val("toggle_pending", rif.pending, 4'd0);
        rif.clear_refresh = 1'b1;
        step();
        rif.clear_refresh = 1'b0;
        check_val("toggle_done_cleared", {3'd0, rif.refresh_done}, 4'd0);
        step();
        check_queue_empty("toggle");
    endtask

    initial begin
        int c0, r, r2;
        test_reset();
        test_interval(c0);
        test_sequence();
        test_overflow(c0);
        test_collision(r);
        test_reset_mid(r2);
        test_toggle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
